// File: rtl/mem_bit_reader.sv
// mem_bit_reader: reads 64-bit words from the packet memory and serves them
// to the packet parser as an MSB-first bit stream, in fields of 1..16 bits.
// Up to two words are buffered. Valid bits sit at the top of the buffer and
// every bit below them is kept at zero.
module mem_bit_reader #(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 64,
  parameter int FIELD_W = 16,
  parameter int POS_W   = 21
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [ADDR_W:0]    num_words,
  output logic               mem_ceb,
  output logic               mem_web,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               req_valid,
  input  logic [4:0]         req_len,
  output logic               req_ready,
  output logic               rsp_valid,
  output logic [FIELD_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic [POS_W-1:0]   bit_pos,
  output logic               busy,
  output logic               eod
);

  localparam int BUF_W = 2 * DATA_W;
  localparam int CNT_W = $clog2(BUF_W) + 1;
  localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(DATA_W);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]         st_q, st_d;
  logic               busy_q, busy_d;
  logic [ADDR_W:0]    nw_q, nw_d;
  logic [ADDR_W:0]    fetched_q, fetched_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic [4:0]         len_q, len_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [FIELD_W-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic [POS_W-1:0]   pos_q, pos_d;

  logic               accept;
  logic [4:0]         len_eff;
  logic               do_rsp;
  logic               short_rsp;
  logic [CNT_W-1:0]   cons;
  logic [CNT_W-1:0]   cnt_rem;
  logic               capture;

  assign mem_ceb   = (st_q != S_ISSUE);
  assign mem_web   = 1'b1;
  assign mem_addr  = fetched_q[ADDR_W-1:0];
  assign req_ready = busy_q && !pend_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign bit_pos   = pos_q;
  assign busy      = busy_q;
  assign eod       = busy_q && (fetched_q == nw_q) && (cnt_q == '0) && (st_q == S_IDLE);

  // Next-state: fetch FSM, buffer shift/append, request completion, restart.
  always_comb begin
    st_d        = st_q;
    busy_d      = busy_q;
    nw_d        = nw_q;
    fetched_d   = fetched_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    len_d       = len_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    pos_d       = pos_q;

    // A request may complete on the same edge that accepts it.
    accept    = req_valid && req_ready;
    len_eff   = pend_q ? len_q : req_len;
    do_rsp    = 1'b0;
    short_rsp = 1'b0;
    cons      = '0;
    if (pend_q || accept) begin
      if (cnt_q >= {{(CNT_W-5){1'b0}}, len_eff}) begin
        do_rsp = 1'b1;
        cons   = {{(CNT_W-5){1'b0}}, len_eff};
      end else if (fetched_q == nw_q) begin
        // Nothing more will arrive: hand over what is left and flag it.
        do_rsp    = 1'b1;
        short_rsp = 1'b1;
        cons      = cnt_q;
      end
    end
    cnt_rem = cnt_q - cons;
    capture = (st_q == S_WAIT);

    if (start) begin
      // Restart flushes everything; an in-flight read is simply not captured.
      st_d       = S_IDLE;
      busy_d     = 1'b1;
      nw_d       = num_words;
      fetched_d  = '0;
      buf_d      = '0;
      cnt_d      = '0;
      pend_d     = 1'b0;
      len_d      = '0;
      rsp_data_d = '0;
      rsp_err_d  = 1'b0;
      pos_d      = '0;
    end else begin
      case (st_q)
        S_IDLE:  if (busy_q && (fetched_q < nw_q) && (cnt_q <= WORD_BITS)) st_d = S_ISSUE;
        S_ISSUE: st_d = S_WAIT;
        S_WAIT:  st_d = S_IDLE;
        default: st_d = S_IDLE;
      endcase

      // Drop consumed bits off the top, then place a returning word right below what remains.
      buf_d = (buf_q << cons) |
              (capture ? ({mem_rdata, {DATA_W{1'b0}}} >> cnt_rem) : {BUF_W{1'b0}});
      cnt_d = cnt_rem + (capture ? WORD_BITS : {CNT_W{1'b0}});
      if (capture) fetched_d = fetched_q + 1'b1;

      if (do_rsp) begin
        rsp_valid_d = 1'b1;
        // Bits below the valid region are zero, so a short field comes out zero-padded.
        rsp_data_d  = buf_q[BUF_W-1 -: FIELD_W] >> (5'(FIELD_W) - len_eff);
        rsp_err_d   = short_rsp;
        pos_d       = pos_q + {{(POS_W-CNT_W){1'b0}}, cons};
        pend_d      = 1'b0;
      end else if (accept) begin
        pend_d = 1'b1;
        len_d  = req_len;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      st_q        <= S_IDLE;
      busy_q      <= 1'b0;
      nw_q        <= '0;
      fetched_q   <= '0;
      buf_q       <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      len_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      pos_q       <= '0;
    end else begin
      st_q        <= st_d;
      busy_q      <= busy_d;
      nw_q        <= nw_d;
      fetched_q   <= fetched_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      pos_q       <= pos_d;
    end
  end

endmodule
